// File: rtl/spi_master_tx.sv
// SPI mode-0 byte transmitter/receiver: one byte per start, MSB first, with
// a CLK_DIV-cycle chip-select lead and trail around the eight sclk periods.
module spi_master_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_e;

    localparam logic [7:0] HC_LAST = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] hc_q, hc_d;
    logic [2:0] bc_q, bc_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       sclk_q, sclk_d;
    logic       cs_q, cs_d;
    logic       mosi_q, mosi_d;
    logic       hc_end;

    // Every state other than IDLE lasts exactly one half-period.
    assign hc_end = (hc_q == HC_LAST);

    always_comb begin
        state_d   = state_q;
        hc_d      = hc_end ? 8'd0 : hc_q + 8'd1;
        bc_d      = bc_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        unique case (state_q)
            IDLE: begin
                hc_d = 8'd0;
                if (start) begin
                    tx_d    = data_in;
                    mosi_d  = data_in[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bc_d    = 3'd0;
                    state_d = LEAD;
                end
            end
            LEAD, LOW: begin
                if (hc_end) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], miso};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (hc_end) begin
                    sclk_d = 1'b0;
                    if (bc_q == 3'd7) begin
                        state_d = TRAIL;
                    end else begin
                        // mosi moves on the falling edge so it is settled for the next rise
                        bc_d    = bc_q + 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                        state_d = LOW;
                    end
                end
            end
            TRAIL: begin
                if (hc_end) begin
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hc_q      <= 8'd0;
            bc_q      <= 3'd0;
            tx_q      <= 8'd0;
            rx_sh_q   <= 8'd0;
            rx_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            bc_q      <= bc_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: CLK_DIV=2 instance for most scenarios,
// CLK_DIV=1 instance for the fastest-divider case.
module tb_spi_master_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start = 1'b0, loop_en = 1'b0, miso_val = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy, done, sclk, cs, mosi, miso;
    logic [7:0] rx_data;

    logic       start1 = 1'b0, miso1 = 1'b0;
    logic [7:0] data_in1 = 8'h00;
    logic       busy1, done1, sclk1, cs1, mosi1;
    logic [7:0] rx_data1;

    assign miso = loop_en ? mosi : miso_val;

    always #5 clk = ~clk;

    spi_master_tx #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
        .cs(cs), .mosi(mosi), .miso(miso)
    );

    spi_master_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data_in1),
        .busy(busy1), .done(done1), .rx_data(rx_data1), .sclk(sclk1),
        .cs(cs1), .mosi(mosi1), .miso(miso1)
    );

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor on the CLK_DIV=2 instance, sampled on the falling clk edge.
    logic [7:0] mon_bits = 8'h00;
    int         mon_rises = 0, mon_cs_low = 0, mon_cs_last = 0;
    int         mon_cs_high = 0, mon_gap = 0, mon_done_cnt = 0;
    bit         mon_busy_bad = 1'b0;
    logic       sclk_prev = 1'b0, cs_prev = 1'b1;

    always @(negedge clk) begin
        if (!cs && cs_prev) begin
            mon_gap    = mon_cs_high;
            mon_cs_low = 0;
            mon_rises  = 0;
            mon_bits   = 8'h00;
        end
        if (cs && !cs_prev) mon_cs_last = mon_cs_low;
        if (cs) begin
            if (!cs_prev) mon_cs_high = 0;
            mon_cs_high++;
        end else begin
            mon_cs_low++;
            if (!busy) mon_busy_bad = 1'b1;
        end
        if (sclk && !sclk_prev) begin
            mon_bits = {mon_bits[6:0], mosi};
            mon_rises++;
        end
        if (done) mon_done_cnt++;
        sclk_prev = sclk;
        cs_prev   = cs;
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        start   = 1'b1;
        data_in = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cs, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got cs=%b sclk=%b mosi=%b busy=%b done=%b rx=%h want 1 0 0 0 0 00",
                     cs, sclk, mosi, busy, done, rx_data);
        end
        checks++;
        if ({cs1, sclk1, busy1, done1} !== 4'b1000 || rx_data1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state_div1 got cs=%b sclk=%b busy=%b done=%b rx=%h want 1 0 0 0 00",
                     cs1, sclk1, busy1, done1, rx_data1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        bit   ok;
        loop_en  = 1'b0;
        miso_val = 1'b0;
        exp_q.push_back('{tx: 8'hA5, rx: 8'h00});
        send(8'hA5);
        mon_done_cnt = 0;
        mon_busy_bad = 1'b0;
        checks++;
        if ({cs, busy, mosi} !== 3'b011) begin
            errors++;
            $display("FAIL basic_accept got cs=%b busy=%b mosi=%b want 0 1 1", cs, busy, mosi);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (mon_bits !== e.tx || mon_rises != 8) begin
            errors++;
            $display("FAIL basic_mosi got %h rises %0d want %h rises 8", mon_bits, mon_rises, e.tx);
        end
        checks++;
        if (mon_cs_last != 34) begin
            errors++;
            $display("FAIL basic_cs_low got %0d want 34", mon_cs_last);
        end
        checks++;
        if (rx_data !== e.rx || busy !== 1'b0 || mon_busy_bad) begin
            errors++;
            $display("FAIL basic_done got rx=%h busy=%b early_busy_drop=%0d want rx=%h busy=0 0",
                     rx_data, busy, mon_busy_bad, e.rx);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || mon_done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b count=%0d want 0 1", done, mon_done_cnt);
        end
    endtask

    task automatic test_loopback();
        exp_t e;
        bit   ok;
        loop_en = 1'b1;
        exp_q.push_back('{tx: 8'h3C, rx: 8'h3C});
        send(8'h3C);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL loop_timeout got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (rx_data !== e.rx || mon_bits !== e.tx) begin
            errors++;
            $display("FAIL loop_rx got rx=%h mosi=%h want %h %h", rx_data, mon_bits, e.rx, e.tx);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        bit   ok;
        loop_en = 1'b1;
        exp_q.push_back('{tx: 8'h5A, rx: 8'h5A});
        send(8'h5A);
        mon_done_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        start   = 1'b1;
        data_in = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore_timeout got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (mon_bits !== e.tx || rx_data !== e.rx || mon_cs_last != 34 || mon_done_cnt != 1) begin
            errors++;
            $display("FAIL ignore_start got mosi=%h rx=%h cs_low=%0d dones=%0d want %h %h 34 1",
                     mon_bits, rx_data, mon_cs_last, mon_done_cnt, e.tx, e.rx);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        loop_en = 1'b1;
        exp_q.push_back('{tx: 8'h00, rx: 8'h00});
        exp_q.push_back('{tx: 8'hFF, rx: 8'hFF});
        @(posedge clk); #1;
        start   = 1'b1;
        data_in = 8'h00;
        @(posedge clk); #1;
        data_in = 8'hFF;
        mon_done_cnt = 0;
        checks++;
        if ({cs, busy, mosi} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_accept1 got cs=%b busy=%b mosi=%b want 0 1 0", cs, busy, mosi);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout1 got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (mon_bits !== e.tx || rx_data !== e.rx) begin
            errors++;
            $display("FAIL b2b_first got mosi=%h rx=%h want %h %h", mon_bits, rx_data, e.tx, e.rx);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({cs, busy, mosi} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_accept2 got cs=%b busy=%b mosi=%b want 0 1 1", cs, busy, mosi);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout2 got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (mon_bits !== e.tx || rx_data !== e.rx || mon_gap != 1 || mon_cs_last != 34 || mon_done_cnt != 2) begin
            errors++;
            $display("FAIL b2b_second got mosi=%h rx=%h gap=%0d cs_low=%0d dones=%0d want %h %h 1 34 2",
                     mon_bits, rx_data, mon_gap, mon_cs_last, mon_done_cnt, e.tx, e.rx);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        loop_en = 1'b1;
        send(8'h96);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (mon_rises == 3) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_third_rise got rises=%0d want 3", mon_rises);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cs, sclk, busy, done} !== 4'b1000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_abort got cs=%b sclk=%b busy=%b done=%b rx=%h want 1 0 0 0 00",
                     cs, sclk, busy, done, rx_data);
        end
        rst = 1'b0;
        mon_done_cnt = 0;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (mon_done_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_no_done got %0d dones want 0", mon_done_cnt);
        end
        exp_q.push_back('{tx: 8'h81, rx: 8'h81});
        send(8'h81);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_timeout got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (mon_bits !== e.tx || rx_data !== e.rx || mon_cs_last != 34) begin
            errors++;
            $display("FAIL rstmid_after got mosi=%h rx=%h cs_low=%0d want %h %h 34",
                     mon_bits, rx_data, mon_cs_last, e.tx, e.rx);
        end
    endtask

    task automatic test_clkdiv1();
        exp_t       e;
        int         low, toggles_bad, rises;
        logic [7:0] bits;
        logic       prev_s;
        bit         seen_done;
        miso1 = 1'b1;
        exp_q.push_back('{tx: 8'hF0, rx: 8'hFF});
        @(posedge clk); #1;
        start1   = 1'b1;
        data_in1 = 8'hF0;
        @(posedge clk); #1;
        start1 = 1'b0;
        low = 0; toggles_bad = 0; rises = 0; bits = 8'h00; prev_s = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 60 && !seen_done; i++) begin
            @(negedge clk);
            if (!cs1) begin
                if (low > 0 && sclk1 === prev_s) toggles_bad++;
                if (sclk1 && !prev_s) begin
                    bits = {bits[6:0], mosi1};
                    rises++;
                end
                low++;
            end
            if (done1) seen_done = 1'b1;
            prev_s = sclk1;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL div1_timeout got no done want done");
        end
        e = exp_q.pop_front();
        checks++;
        if (low != 17 || toggles_bad != 0) begin
            errors++;
            $display("FAIL div1_timing got cs_low=%0d missed_toggles=%0d want 17 0", low, toggles_bad);
        end
        checks++;
        if (bits !== e.tx || rises != 8 || rx_data1 !== e.rx) begin
            errors++;
            $display("FAIL div1_data got mosi=%h rises=%0d rx=%h want %h 8 %h",
                     bits, rises, rx_data1, e.tx, e.rx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loopback();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 2, clk cycles per sclk half-period, legal range 1..255.
REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  input  1  system clock; all logic on rising edge; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  transfer request; sampled each clk.
- data_in  input  8  byte to transmit; captured when start is accepted.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-clk pulse at transfer end.
- rx_data  output  8  byte captured from miso; valid from the done cycle until the next done.
- sclk  output  1  SPI clock, mode 0 (idles low).
- cs  output  1  active-low chip select.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in; synchronous to clk.
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The state machine SHALL have the states IDLE, LEAD, HIGH, LOW and TRAIL, plus a half-period counter hc (0..CLK_DIV-1) and a bit counter bc (0..7).
REQ-005 In IDLE, start=1 SHALL be accepted and SHALL latch data_in into the shift register, drive mosi=data_in[7] and cs=0, set busy=1 and bc=0, and enter LEAD, all visible on the next cycle.
REQ-006 start while busy=1 SHALL be ignored; data_in changes while busy SHALL have no effect.
REQ-007 LEAD SHALL hold cs=0 and sclk=0 for CLK_DIV cycles, then drive sclk=1 and enter HIGH.
REQ-008 On the cycle sclk goes 1, miso SHALL be sampled into the receive shift register, MSB first.
REQ-009 HIGH SHALL hold sclk=1 for CLK_DIV cycles, then drive sclk=0.
- If bc=7, it SHALL enter TRAIL.
- Otherwise it SHALL increment bc, shift mosi to the next lower bit in the same cycle, and enter LOW.
REQ-010 LOW SHALL hold sclk=0 for CLK_DIV cycles, then drive sclk=1 and enter HIGH.
REQ-011 mosi SHALL change only on sclk falling edges or at start acceptance, and SHALL be stable for every sclk rising edge.
REQ-012 TRAIL SHALL hold cs=0 and sclk=0 for CLK_DIV cycles, then in one cycle: cs=1, busy=0, done=1, rx_data=receive register, and return to IDLE.
REQ-013 Exactly 8 sclk rising edges SHALL occur per transfer.
REQ-014 cs SHALL be low for exactly 17*CLK_DIV cycles.
REQ-015 done SHALL be high for exactly one cycle per completed transfer.
REQ-016 start asserted during the done cycle SHALL be accepted, giving back-to-back transfers with cs high for exactly 1 cycle between them.
REQ-017 In IDLE, mosi SHALL hold its last driven value; a value of 0 after reset is acceptable.
REQ-018 Counter wrap: hc SHALL reset to 0 on every state change; bc SHALL never exceed 7.

Reset
REQ-019 On rst=1 at a clk edge, the following SHALL hold on the next cycle: state=IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0x00, hc=0, bc=0.
REQ-020 rst asserted mid-transfer SHALL abort immediately with no done pulse; rx_data SHALL be cleared to 0x00.
REQ-021 rst SHALL take priority over start in the same cycle.

Verification
REQ-022 CLK_DIV=2, start with data_in=0xA5 -> mosi at the 8 sclk rises = 1,0,1,0,0,1,0,1; cs low 34 cycles; one done pulse; busy low only after done.
REQ-023 miso looped to mosi, send 0x3C -> rx_data=0x3C at done.
REQ-024 start held high across a 0x00 transfer and into its done cycle with data_in=0xFF -> two transfers, cs high exactly 1 cycle between them, second mosi all ones.
REQ-025 start pulsed mid-transfer with a different data_in -> ignored; the original byte completes unchanged.
REQ-026 rst pulsed after the 3rd sclk rise -> next cycle cs=1, sclk=0, busy=0; no done; a following start with 0x81 completes correctly.
REQ-027 CLK_DIV=1, send 0xF0 with miso held at 1 -> cs low 17 cycles; sclk toggles every cycle; rx_data=0xFF.
